// File: rtl/mitch_div_pipe_if.sv
// mitch_div_pipe_if: valid/ready bundle for the Mitchell divider
//   master : drives in_valid, x, y, out_ready; observes in_ready, out_valid, q, div0
//   slave  : the divider side of the same bundle
interface mitch_div_pipe_if #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        x;
    logic [WIDTH-1:0]        y;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH+FRAC-1:0]   q;
    logic                    div0;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, q, div0
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, q, div0
    );
endinterface

// File: rtl/mitch_div_pipe.sv
// mitch_div_pipe: 3-stage pipelined Mitchell approximate divider, q ~= x / y in Q(WIDTH).(FRAC)
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of mitch_div_pipe_if (in_valid/in_ready/x/y, out_valid/out_ready/q/div0)
module mitch_div_pipe #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic            clk,
    input  logic            rst,
    mitch_div_pipe_if.slave bus
);
    localparam int KW  = $clog2(WIDTH);
    localparam int FW  = WIDTH - 1;
    localparam int SSW = KW + 2;
    localparam int QW  = WIDTH + FRAC;
    localparam int WW  = 2 * WIDTH + FRAC - 1;
    localparam int SW  = $clog2(3 * WIDTH) + 1;

    function automatic logic [KW-1:0] lead_one(input logic [WIDTH-1:0] v);
        lead_one = '0;
        for (int i = 0; i < WIDTH; i++)
            if (v[i]) lead_one = KW'(i);
    endfunction

    // Fraction bits below the leading one, left-aligned into FW bits.
    function automatic logic [FW-1:0] mant(input logic [WIDTH-1:0] v, input logic [KW-1:0] k);
        mant = FW'(v << (KW'(WIDTH - 1) - k));
    endfunction

    logic                  en;
    logic                  v1, v2;
    logic [KW-1:0]         k1, k2;
    logic [FW-1:0]         f1, f2;
    logic                  zx1, zy1, zx2, zy2;
    logic [WIDTH-1:0]      m2;
    logic signed [SSW-1:0] s2;
    logic [WIDTH-1:0]      d;
    logic signed [SSW-1:0] e;
    logic [WIDTH-1:0]      m_n;
    logic signed [SSW-1:0] s_n;
    logic [SW-1:0]         rs;
    logic [WW-1:0]         wide;
    logic [QW-1:0]         q_n;

    assign en           = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = en;

    // A borrow in the fraction difference wraps d by 2^(WIDTH-1) for free,
    // so the mantissa is always 1.d[WIDTH-2:0]; only the exponent drops by one.
    assign d   = {1'b0, f1} - {1'b0, f2};
    assign e   = $signed({2'b00, k1}) - $signed({2'b00, k2});
    assign m_n = {1'b1, d[WIDTH-2:0]};
    assign s_n = e - $signed({{(SSW-1){1'b0}}, d[WIDTH-1]});

    // q = m * 2^(s+FRAC-(WIDTH-1)): pre-pad m so every case is a right shift.
    assign rs   = SW'(2 * WIDTH - 2) - {{(SW-SSW){s2[SSW-1]}}, s2};
    assign wide = {m2, {(WW-WIDTH){1'b0}}};
    assign q_n  = zy2 ? '1 : zx2 ? '0 : QW'(wide >> rs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            k1  <= '0;
            k2  <= '0;
            f1  <= '0;
            f2  <= '0;
            zx1 <= 1'b0;
            zy1 <= 1'b0;
        end else if (en) begin
            v1  <= bus.in_valid;
            k1  <= lead_one(bus.x);
            k2  <= lead_one(bus.y);
            f1  <= mant(bus.x, lead_one(bus.x));
            f2  <= mant(bus.y, lead_one(bus.y));
            zx1 <= bus.x == '0;
            zy1 <= bus.y == '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2  <= 1'b0;
            m2  <= '0;
            s2  <= '0;
            zx2 <= 1'b0;
            zy2 <= 1'b0;
        end else if (en) begin
            v2  <= v1;
            m2  <= m_n;
            s2  <= s_n;
            zx2 <= zx1;
            zy2 <= zy1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.q         <= '0;
            bus.div0      <= 1'b0;
        end else if (en) begin
            bus.out_valid <= v2;
            bus.q         <= q_n;
            bus.div0      <= zy2;
        end
    end
endmodule

// File: tb/tb_mitch_div_pipe.sv
// tb_mitch_div_pipe: scoreboard bench for mitch_div_pipe (directed vectors, stalls, reset flush, random vs model)
module tb_mitch_div_pipe;
    typedef struct packed {
        logic        div0;
        logic [23:0] q;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hold_end = 0;
    bit   rand_stall = 1'b0;
    exp_t sb[$];
    exp_t got;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mitch_div_pipe_if bus ();
    mitch_div_pipe dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic dz, input logic [23:0] qv);
        mk = {dz, qv};
    endfunction

    function automatic exp_t model(input int xi, input int yi);
        int kx, ky, f1, f2, df, e, s, m, sh;
        if (yi == 0) return mk(1'b1, 24'hFFFFFF);
        if (xi == 0) return mk(1'b0, 24'h0);
        kx = $clog2(xi + 1) - 1;
        ky = $clog2(yi + 1) - 1;
        f1 = (xi - (1 << kx)) << (15 - kx);
        f2 = (yi - (1 << ky)) << (15 - ky);
        df = f1 - f2;
        e  = kx - ky;
        if (df < 0) begin
            df = df + 32768;
            s  = e - 1;
        end else s = e;
        m  = 32768 + df;
        sh = s + 8 - 15;
        return mk(1'b0, sh >= 0 ? 24'(m << sh) : 24'(m >> (-sh)));
    endfunction

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.out_ready = (cyc < hold_end) ? 1'b0 : rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (bus.out_valid && !bus.out_ready) check("in_ready_stall", 32'(bus.in_ready), 0);
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got q=%h with empty scoreboard", bus.q);
                    end else begin
                        got = sb.pop_front();
                        check("q", 32'(bus.q), 32'(got.q));
                        check("div0", 32'(bus.div0), 32'(got.div0));
                    end
                end
            end
        end
    end

    task automatic send(input int xi, input int yi, input exp_t ex);
        int n = 0;
        @(negedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.x = 16'(xi);
        bus.y = 16'(yi);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=0 want 1");
        end else sb.push_back(ex);
    endtask

    task automatic idle();
        @(negedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 0);
    endtask

    task automatic lat(input int xi, input int yi, input exp_t ex);
        send(xi, yi, ex);
        @(negedge clk);
        #1;
        bus.in_valid = 1'b0;
        #1;
        check("lat_c1", 32'(bus.out_valid), 0);
        @(negedge clk);
        #2;
        check("lat_c2", 32'(bus.out_valid), 0);
        @(negedge clk);
        #2;
        check("lat_c3", 32'(bus.out_valid), 1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.x = '0;
        bus.y = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_q", 32'(bus.q), 0);
        check("rst_div0", 32'(bus.div0), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        lat(48, 3, mk(1'b0, 24'h001000));
        drain();

        send(100, 7, mk(1'b0, 24'h000E80));
        send(1000, 10, mk(1'b0, 24'h006D00));
        send(65535, 1, mk(1'b0, 24'hFFFF00));
        send(1, 65535, mk(1'b0, 24'h000000));
        send(5, 0, mk(1'b1, 24'hFFFFFF));
        send(0, 0, mk(1'b1, 24'hFFFFFF));
        send(0, 9, mk(1'b0, 24'h000000));
        idle();
        drain();

        for (int i = 0; i < 8; i++) begin
            int xi = 300 + 977 * i;
            int yi = 3 + 11 * i;
            if (i == 3) hold_end = cyc + 4;
            send(xi, yi, model(xi, yi));
        end
        idle();
        drain();

        rand_stall = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            int xi = $urandom_range(0, 65535);
            int yi = ($urandom_range(0, 31) == 0) ? 0 : $urandom_range(1, 65535);
            send(xi, yi, model(xi, yi));
            if ($urandom_range(0, 7) == 0) idle();
        end
        idle();
        rand_stall = 1'b0;
        drain();

        send(1000, 10, mk(1'b0, 24'h006D00));
        send(100, 7, mk(1'b0, 24'h000E80));
        @(negedge clk);
        #1;
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 0);
        check("midrst_q", 32'(bus.q), 0);
        check("midrst_div0", 32'(bus.div0), 0);
        sb.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        lat(65535, 1, mk(1'b0, 24'hFFFF00));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
